// File: rtl/lsm_pipelined.sv
// Load-store unit between execute and writeback: issues pipelined Wishbone requests,
// tracks up to MAX_OUTSTANDING in flight and retires results in program order.
module lsm_pipelined #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] alu_result_i,
    input  logic        enable_i,
    input  logic        write_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  sel_i,
    input  logic        unsigned_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic       reg_write;
        logic [4:0] reg_addr;
        logic [3:0] sel;
        logic       is_unsigned;
        logic       we;
    } entry_t;

    entry_t           fifo_q [MAX_OUTSTANDING];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pending_nxt;
    logic [CNT_W-1:0] occupancy;
    logic             accept;
    logic             mem_accept;
    logic             alu_accept;
    logic             transfer;
    logic             ack_hit;
    logic             stb_nxt;

    // Bit offset of the lowest enabled byte lane.
    function automatic logic [4:0] lane_shift(input logic [3:0] sel);
        case (sel)
            4'b0010:          lane_shift = 5'd8;
            4'b0100, 4'b1100: lane_shift = 5'd16;
            4'b1000:          lane_shift = 5'd24;
            default:          lane_shift = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] raw, input logic [3:0] sel,
                                                input logic is_unsigned);
        logic [31:0]        shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        shifted = raw >> lane_shift(sel);
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (sel)
            4'b1111:          format_load = shifted;
            4'b0011, 4'b1100: format_load = is_unsigned ? {16'h0000, shifted[15:0]} : 32'(half_s);
            default:          format_load = is_unsigned ? {24'h000000, shifted[7:0]} : 32'(byte_s);
        endcase
    endfunction

    always_comb begin
        occupancy     = pending + CNT_W'(wb_stb_o);
        input_ready_o = 1'b0;
        if (enable_i) begin
            input_ready_o = !(wb_stb_o && wb_stall_i) && (occupancy < MAX_CNT);
        end else begin
            input_ready_o = (pending == '0) && !wb_stb_o;
        end
    end

    always_comb begin
        accept      = input_valid_i && input_ready_o;
        mem_accept  = accept && enable_i;
        alu_accept  = accept && !enable_i;
        transfer    = wb_stb_o && !wb_stall_i;
        ack_hit     = wb_ack_i && (pending != '0);
        head        = fifo_q[rd_ptr];
        push_entry  = '{reg_write: reg_write_i, reg_addr: reg_addr_i, sel: sel_i,
                        is_unsigned: unsigned_i, we: write_i};
        pending_nxt = pending;
        case ({transfer, ack_hit})
            2'b10:   pending_nxt = pending + CNT_W'(1);
            2'b01:   pending_nxt = pending - CNT_W'(1);
            default: pending_nxt = pending;
        endcase
        stb_nxt = wb_stb_o;
        if (mem_accept) begin
            stb_nxt = 1'b1;
        end else if (transfer) begin
            stb_nxt = 1'b0;
        end
    end

    // Tracking storage holds only payload; validity comes from the reset pointers.
    always_ff @(posedge clk_i) begin
        if (mem_accept) begin
            fifo_q[wr_ptr] <= push_entry;
        end
    end

    // Issue stage: Wishbone request register and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
        end else begin
            pending  <= pending_nxt;
            wb_stb_o <= stb_nxt;
            wb_cyc_o <= stb_nxt || (pending_nxt != '0);
            if (mem_accept) begin
                wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                wb_adr_o <= alu_result_i;
                wb_dat_o <= write_data_i << lane_shift(sel_i);
                wb_we_o  <= write_i;
                wb_sel_o <= sel_i;
            end
            if (ack_hit) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Retire stage: acks and non-memory results share the single writeback port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
            reg_addr_o     <= '0;
            reg_data_o     <= '0;
        end else if (ack_hit) begin
            output_valid_o <= 1'b1;
            reg_write_o    <= head.reg_write;
            reg_addr_o     <= head.reg_addr;
            reg_data_o     <= head.we ? 32'h0 : format_load(wb_dat_i, head.sel, head.is_unsigned);
        end else if (alu_accept) begin
            output_valid_o <= 1'b1;
            reg_write_o    <= reg_write_i;
            reg_addr_o     <= reg_addr_i;
            reg_data_o     <= alu_result_i;
        end else begin
            output_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsm_pipelined.sv
// Bench for lsm_pipelined: queue-based reference model checked every cycle, a
// latency-programmable Wishbone slave, and directed vectors with literal results.
module tb_lsm_pipelined;

    localparam int MAXO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        input_ready_o;
    logic        input_valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic        enable_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] write_data_i = '0;
    logic [3:0]  sel_i = '0;
    logic        unsigned_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  reg_addr_i = '0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_cyc_o;
    logic        wb_stall_i = 1'b0;
    logic        output_valid_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;

    lsm_pipelined #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .input_ready_o(input_ready_o),
        .input_valid_i(input_valid_i), .alu_result_i(alu_result_i), .enable_i(enable_i),
        .write_i(write_i), .write_data_i(write_data_i), .sel_i(sel_i),
        .unsigned_i(unsigned_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
        .wb_stall_i(wb_stall_i), .output_valid_o(output_valid_o), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        uns;
        logic        rw;
        logic [4:0]  ra;
    } op_t;

    typedef struct {
        int          due;
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        int          ack_at;
        logic [31:0] adr;
    } sreq_t;

    op_t   op_q[$];
    op_t   inflight_q[$];
    exp_t  exp_q[$];
    sreq_t sq[$];

    int n_tests = 0;
    int n_fail = 0;
    int ncnt = 0;
    int xfer_total = 0;
    int ack_lat = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] adr);
        if (adr == 32'h100) return 32'hDEADBEEF;
        if (adr[31:4] == 28'h20) return 32'h00800000;
        if (adr == 32'h300) return 32'h80010000;
        return {adr[15:0], ~adr[15:0]};
    endfunction

    function automatic int low_lane(input logic [3:0] sel);
        int lo = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) lo = i;
        return lo;
    endfunction

    function automatic logic [31:0] model_load(input op_t o, input logic [31:0] raw);
        int          nbytes = 0;
        int          w;
        logic [31:0] v;
        logic [31:0] mask;
        if (o.we) return 32'h0;
        for (int i = 0; i < 4; i++) if (o.sel[i]) nbytes++;
        w = 8 * nbytes;
        v = raw >> (8 * low_lane(o.sel));
        if (w < 32) begin
            mask = (32'h1 << w) - 32'h1;
            v = v & mask;
            if (!o.uns && v[w-1]) v = v | ~mask;
        end
        return v;
    endfunction

    op_t  cur_op;
    logic stb_m;
    logic exp_ready;

    // Reference model: state after each rising edge, checked at the falling edge.
    always @(negedge clk_i) begin
        if (wb_stb_o && !wb_stall_i) sq.push_back('{ncnt + ack_lat, wb_adr_o});
        if (rst_i) begin
            check("rst_stb", wb_stb_o, 0);
            check("rst_cyc", wb_cyc_o, 0);
            check("rst_valid", output_valid_o, 0);
            check("rst_reg_data", reg_data_o, 0);
            op_q.delete();
            inflight_q.delete();
            exp_q.delete();
        end else begin
            stb_m = (op_q.size() != 0);
            if (exp_q.size() != 0 && exp_q[0].due == ncnt) begin
                check("mdl_valid", output_valid_o, 1);
                check("mdl_reg_write", reg_write_o, exp_q[0].rw);
                check("mdl_reg_addr", reg_addr_o, exp_q[0].ra);
                check("mdl_reg_data", reg_data_o, exp_q[0].d);
                void'(exp_q.pop_front());
            end else begin
                check("mdl_no_valid", output_valid_o, 0);
            end
            check("mdl_stb", wb_stb_o, stb_m);
            if (stb_m) begin
                check("mdl_adr", wb_adr_o, op_q[0].adr);
                check("mdl_dat", wb_dat_o, op_q[0].wd << (8 * low_lane(op_q[0].sel)));
                check("mdl_we", wb_we_o, op_q[0].we);
                check("mdl_sel", wb_sel_o, op_q[0].sel);
            end
            check("mdl_cyc", wb_cyc_o, stb_m || inflight_q.size() != 0);
            if (enable_i)
                exp_ready = !(stb_m && wb_stall_i) && (op_q.size() + inflight_q.size() < MAXO);
            else
                exp_ready = !stb_m && inflight_q.size() == 0;
            check("mdl_ready", input_ready_o, exp_ready);
            if (wb_ack_i && inflight_q.size() != 0) begin
                cur_op = inflight_q.pop_front();
                exp_q.push_back('{ncnt + 1, cur_op.rw, cur_op.ra, model_load(cur_op, wb_dat_i)});
            end
            if (stb_m && !wb_stall_i) begin
                cur_op = op_q.pop_front();
                inflight_q.push_back(cur_op);
                xfer_total++;
            end
            if (input_valid_i && input_ready_o) begin
                if (enable_i)
                    op_q.push_back('{write_i, alu_result_i, write_data_i, sel_i, unsigned_i,
                                     reg_write_i, reg_addr_i});
                else
                    exp_q.push_back('{ncnt + 1, reg_write_i, reg_addr_i, alu_result_i});
            end
        end
        ncnt++;
    end

    // Wishbone slave: acks in request order ack_lat cycles after each transfer.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (sq.size() != 0 && sq[0].ack_at <= ncnt) begin
            wb_ack_i = 1'b1;
            wb_dat_i = slave_data(sq[0].adr);
            void'(sq.pop_front());
        end else begin
            wb_ack_i = 1'b0;
            wb_dat_i = '0;
        end
    end

    task automatic present(input logic en, input logic we, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [3:0] sel, input logic uns,
                           input logic rw, input logic [4:0] ra);
        enable_i      = en;
        write_i       = we;
        alu_result_i  = alu;
        write_data_i  = wd;
        sel_i         = sel;
        unsigned_i    = uns;
        reg_write_i   = rw;
        reg_addr_i    = ra;
        input_valid_i = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        logic acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_i);
            acc = input_ready_o;
            @(posedge clk_i);
            #1;
        end
        input_valid_i = 1'b0;
        check({name, "_accepted"}, acc, 1);
    endtask

    task automatic issue(input string name, input logic en, input logic we, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [3:0] sel, input logic uns,
                         input logic rw, input logic [4:0] ra);
        present(en, we, alu, wd, sel, uns, rw, ra);
        wait_accept(name);
    endtask

    task automatic wait_result(input string name, input logic rw, input logic [4:0] ra,
                               input logic [31:0] d);
        logic got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_i);
            if (output_valid_o) begin
                got = 1'b1;
                check({name, "_reg_write"}, reg_write_o, rw);
                check({name, "_reg_addr"}, reg_addr_o, ra);
                check({name, "_reg_data"}, reg_data_o, d);
            end
            @(posedge clk_i);
            #1;
        end
        check({name, "_retired"}, got, 1);
    endtask

    initial begin
        int base;
        int vcnt;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ready", input_ready_o, 1);
        check("reset_stb", wb_stb_o, 0);
        check("reset_cyc", wb_cyc_o, 0);
        check("reset_valid", output_valid_o, 0);
        check("reset_adr", wb_adr_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        ack_lat = 1;
        issue("word", 1, 0, 32'h100, 0, 4'b1111, 0, 1, 5'd5);
        wait_result("word", 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk_i);
        check("word_cyc_closed", wb_cyc_o, 0);
        @(posedge clk_i);
        #1;

        issue("lb", 1, 0, 32'h200, 0, 4'b0100, 0, 1, 5'd10);
        wait_result("lb", 1, 5'd10, 32'hFFFFFF80);
        issue("lbu", 1, 0, 32'h204, 0, 4'b0100, 1, 1, 5'd11);
        wait_result("lbu", 1, 5'd11, 32'h00000080);
        issue("lh", 1, 0, 32'h300, 0, 4'b1100, 0, 1, 5'd12);
        wait_result("lh", 1, 5'd12, 32'hFFFF8001);

        issue("sb", 1, 1, 32'h500, 32'h000000AB, 4'b0010, 0, 0, 5'd0);
        @(negedge clk_i);
        check("sb_wb_dat", wb_dat_o, 32'h0000AB00);
        check("sb_wb_we", wb_we_o, 1);
        @(posedge clk_i);
        #1;
        wait_result("sb", 0, 5'd0, 32'h0);

        ack_lat = 6;
        base = xfer_total;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    issue("pipe", 1, 0, 32'h1000 + 32'(4 * k), 0, 4'b1111, 0, 1, 5'(k));
            end
            begin
                wait_result("pipe1", 1, 5'd1, 32'h1004EFFB);
                check("pipe_xfers_before_first_ack", 32'(xfer_total - base), 4);
                wait_result("pipe2", 1, 5'd2, 32'h1008EFF7);
                wait_result("pipe3", 1, 5'd3, 32'h100CEFF3);
                wait_result("pipe4", 1, 5'd4, 32'h1010EFEF);
                wait_result("pipe5", 1, 5'd5, 32'h1014EFEB);
            end
        join

        ack_lat = 1;
        wb_stall_i = 1'b1;
        issue("stall_ld", 1, 0, 32'h400, 0, 4'b1111, 0, 1, 5'd6);
        present(0, 0, 32'h42, 0, 4'b0000, 0, 1, 5'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_adr_hold", wb_adr_o, 32'h400);
            check("stall_ready_low", input_ready_o, 0);
            @(posedge clk_i);
            #1;
        end
        wb_stall_i = 1'b0;
        fork
            wait_accept("alu7");
            begin
                wait_result("stall_ld", 1, 5'd6, 32'h0400FBFF);
                wait_result("alu7", 1, 5'd7, 32'h42);
            end
        join

        ack_lat = 4;
        issue("rst_ld1", 1, 0, 32'h600, 0, 4'b1111, 0, 1, 5'd8);
        issue("rst_ld2", 1, 0, 32'h604, 0, 4'b1111, 0, 1, 5'd9);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_rst_stb", wb_stb_o, 0);
        check("async_rst_cyc", wb_cyc_o, 0);
        check("async_rst_adr", wb_adr_o, 0);
        check("async_rst_dat", wb_dat_o, 0);
        check("async_rst_we_sel", {wb_we_o, wb_sel_o}, 0);
        check("async_rst_valid", output_valid_o, 0);
        check("async_rst_reg", {reg_write_o, reg_addr_o}, 0);
        check("async_rst_reg_data", reg_data_o, 0);
        check("async_rst_ready", input_ready_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (output_valid_o) vcnt++;
        end
        check("post_rst_stale_acks", 32'(vcnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

endmodule

// File: doc/lsm_pipelined.md
# lsm_pipelined

Parametrised load-store module for the ECAP5-DPROC pipeline. It sits between execute and writeback and drives a pipelined Wishbone master. It keeps up to MAX_OUTSTANDING memory transactions in flight, positions store data on the correct byte lanes, and extracts and sign- or zero-extends load data. Results retire in order through a single writeback port.

## Interface
- MAX_OUTSTANDING, 4, maximum number of accepted but not yet acknowledged memory transactions; power of two, 1..16
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- input_ready_o  out  1  block can accept an instruction this cycle
- input_valid_i  in  1  instruction valid
- alu_result_i  in  32  memory address, or result of a non-memory instruction
- enable_i  in  1  instruction is a memory access
- write_i  in  1  store (1) / load (0)
- write_data_i  in  32  raw register value to store, unshifted
- sel_i  in  4  byte lanes; legal values: 0001, 0010, 0100, 1000, 0011, 1100, 1111
- unsigned_i  in  1  load is zero-extended (1) or sign-extended (0)
- reg_write_i  in  1  instruction writes a register
- reg_addr_i  in  5  destination register
- wb_adr_o  out  32  Wishbone address
- wb_dat_i  in  32  Wishbone read data
- wb_dat_o  out  32  Wishbone write data, lane-shifted
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_stb_o  out  1  Wishbone strobe
- wb_ack_i  in  1  Wishbone acknowledge, in request order
- wb_cyc_o  out  1  Wishbone cycle
- wb_stall_i  in  1  Wishbone stall
- output_valid_o  out  1  one-cycle pulse: result on reg_* is valid
- reg_write_o  out  1  writeback enable
- reg_addr_o  out  5  writeback register
- reg_data_o  out  32  writeback data

## Operation
- **Accept:** an instruction is accepted when input_valid_i && input_ready_o.
- **input_ready_o** is combinational from registered state and enable_i:
  - memory op: !(wb_stb_o && wb_stall_i) && count < MAX_OUTSTANDING
  - non-memory op: count == 0 && !wb_stb_o
- **Occupancy:**
  - pending = transfers accepted by the slave (stb && !stall) but not yet acked.
  - count = pending + wb_stb_o.
- **Tracking FIFO:** MAX_OUTSTANDING entries, each holding {reg_write, reg_addr, sel, unsigned, we}.
  - Push on memory-op accept.
  - Pop on wb_ack_i.
  - Pointers wrap modulo MAX_OUTSTANDING.
- **Issue register:**
  - On accept it loads wb_adr = alu_result_i, wb_we = write_i, wb_sel = sel_i, wb_stb = 1.
  - wb_dat = write_data_i << (8 × index of the lowest set bit of sel_i).
  - The register holds every value while wb_stall_i is high.
  - On transfer (stb && !stall) with no new accept, wb_stb drops to 0 and adr/dat/we/sel keep their values.
  - On transfer with a simultaneous accept, the new request loads back-to-back and stb stays 1.
- **wb_cyc_o (registered):** next value = next_stb || next_pending != 0.
- **Load formatting on ack:** shift wb_dat_i right by 8 × lowest-lane index.
  - Take 8 bits for single-lane sel, 16 bits for two-lane sel, 32 bits for 1111.
  - Extend with the entry's unsigned flag.
  - Stores on ack: reg_data = 0.
- **Retire:**
  - Memory op: on ack, register reg_write = entry.reg_write, reg_addr = entry.reg_addr, reg_data = formatted data, output_valid = 1.
  - Non-memory op: on accept, register reg_write_i, reg_addr_i, alu_result_i, output_valid = 1.
- **Ordering:** non-memory ops wait for the FIFO to drain, so results retire in program order. At most one result retires per cycle.
- **Illegal sel values** are out of contract; there is no required behaviour.

## Timing
- **Reset values:** all registered outputs are 0. input_ready_o = 1 with no pending state. Reset clears the FIFO and counters immediately, at any time, including mid-transaction.
- **Acks while empty:** acks arriving while pending == 0 (for example after a reset mid-operation, or spurious) are ignored: no pop, no output.
- **Latencies:**
  - Accept to wb_stb_o: 1 cycle.
  - Ack to output_valid_o: 1 cycle.
  - Non-memory accept to output_valid_o: 1 cycle.
- **Simultaneous events:**
  - Transfer and ack in the same cycle leave pending unchanged.
  - Push and pop in the same cycle leave the FIFO count unchanged.
- **Back-to-back memory ops:** with no stall, MAX_OUTSTANDING transfers issue on consecutive cycles. The next accept then waits until an ack frees a slot; ready rises combinationally in the cycle after that ack.
- **Cycle close:** wb_cyc_o falls in the cycle after the last ack when nothing else is queued.

## Test plan
- **Word load:** load adr 0x100, sel 1111, reg 5; slave acks the cycle after stb with 0xDEADBEEF -> stb high 1 cycle, output_valid_o pulse with reg_addr 5, reg_data 0xDEADBEEF, then cyc 0.
- **Byte/halfword loads:**
  - Signed byte, sel 0100, wb_dat_i 0x00800000 -> reg_data 0xFFFFFF80.
  - Unsigned, same input -> 0x00000080.
  - Signed half, sel 1100, wb_dat_i 0x80010000 -> 0xFFFF8001.
- **Store lane shift:** sel 0010, write_data_i 0x000000AB -> wb_dat_o 0x0000AB00, wb_we_o 1; on ack the output has reg_write 0.
- **Full pipeline (MAX_OUTSTANDING 4):** 5 back-to-back loads, acks delayed 6 cycles -> 4 stb cycles, input_ready_o 0 until the first ack, then the fifth issues. Outputs retire in order with the correct reg_addr values.
- **Stall and ordering:** wb_stall_i high for 3 cycles on the first load -> wb_adr_o stable and ready low for the stall. A non-memory op (alu 0x42, reg 7) presented next is held until all acks arrive, then retires 1 cycle after acceptance.
- **Reset mid-operation:** assert rst_i asynchronously with 2 transfers pending -> all outputs 0 immediately. Acks arriving after release produce no output_valid_o.
